// File: rtl/i2c_slave_regs_if.sv
// Pin-level I2C signals plus the write-commit strobe of the register slave.
// wr_stb is a one-cycle valid with no ready: wr_addr/wr_data are meaningful only while it is 1.
interface i2c_slave_regs_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [3:0] dbg_state;

  modport slave (
    input  scl_i, sda_i,
    output sda_oe, wr_stb, wr_addr, wr_data, busy, dbg_state
  );

  modport master (
    output scl_i, sda_i,
    input  sda_oe, wr_stb, wr_addr, wr_data, busy, dbg_state
  );
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C slave exposing a 256x8 register file behind an 8-bit auto-incrementing pointer.
// scl/sda are synchronised and glitch-filtered in the system clock domain before use.
module i2c_slave_regs #(
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         FILT_LEN = 3
) (
  input logic            i_clk,
  input logic            i_rst,
  i2c_slave_regs_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WORD_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  logic [1:0]          scl_sync, sda_sync;
  logic [FILT_LEN-1:0] scl_hist, sda_hist;
  logic                scl_f, sda_f, scl_d, sda_d;
  logic                scl_rise, scl_fall, start_det, stop_det;

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic [7:0] ptr, ptr_n;
  logic       sda_oe, sda_oe_n;
  logic       busy, busy_n;
  logic       ack_drv, ack_drv_n;
  logic       rw, rw_n;
  logic       wr_stb, wr_stb_n;
  logic [7:0] wr_addr, wr_addr_n;
  logic [7:0] wr_data, wr_data_n;
  logic       mem_we;
  logic [7:0] rx_byte, rd_byte;
  logic [7:0] mem [256];

  // A filtered level only moves once FILT_LEN consecutive samples agree.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_i};
      sda_sync <= {sda_sync[0], bus.sda_i};
      scl_hist <= (scl_hist << 1) | FILT_LEN'(scl_sync[1]);
      sda_hist <= (sda_hist << 1) | FILT_LEN'(sda_sync[1]);
      if (&scl_hist)       scl_f <= 1'b1;
      else if (~|scl_hist) scl_f <= 1'b0;
      if (&sda_hist)       sda_f <= 1'b1;
      else if (~|sda_hist) sda_f <= 1'b0;
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

  assign rx_byte = {shreg[6:0], sda_f};
  assign rd_byte = mem[ptr];

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    sda_oe_n  = sda_oe;
    busy_n    = busy;
    ack_drv_n = ack_drv;
    rw_n      = rw;
    wr_stb_n  = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    mem_we    = 1'b0;
    if (stop_det) begin
      state_n   = IDLE;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      bit_cnt_n = 3'd0;
    end else if (start_det) begin
      state_n   = DEV_ADDR;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      bit_cnt_n = 3'd0;
    end else begin
      unique case (state)
        IDLE: ;
        DEV_ADDR: if (scl_rise) begin
          shreg_n   = rx_byte;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (rx_byte[7:1] == SLV_ADDR) begin
              state_n   = DEV_ACK;
              busy_n    = 1'b1;
              rw_n      = rx_byte[0];
              ack_drv_n = 1'b0;
            end else begin
              state_n = IDLE;
            end
          end
        end
        // First fall after the 8th bit drives ACK; the next fall ends the ACK slot.
        DEV_ACK, WORD_ACK, WR_ACK: if (scl_fall) begin
          if (!ack_drv) begin
            sda_oe_n  = 1'b1;
            ack_drv_n = 1'b1;
          end else begin
            bit_cnt_n = 3'd0;
            sda_oe_n  = 1'b0;
            if (state == DEV_ACK && rw) begin
              state_n  = RD_DATA;
              sda_oe_n = ~rd_byte[7];
            end else if (state == DEV_ACK) begin
              state_n = WORD_ADDR;
            end else begin
              state_n = WR_DATA;
            end
          end
        end
        WORD_ADDR: if (scl_rise) begin
          shreg_n   = rx_byte;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            ptr_n     = rx_byte;
            state_n   = WORD_ACK;
            ack_drv_n = 1'b0;
          end
        end
        WR_DATA: if (scl_rise) begin
          shreg_n   = rx_byte;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            mem_we    = 1'b1;
            wr_stb_n  = 1'b1;
            wr_addr_n = ptr;
            wr_data_n = rx_byte;
            ptr_n     = ptr + 8'd1;
            state_n   = WR_ACK;
            ack_drv_n = 1'b0;
          end
        end
        // bit_cnt counts bits already clocked out, so ~bit_cnt selects the next one MSB first.
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_n = RD_ACK;
          end else if (scl_fall) begin
            sda_oe_n = ~rd_byte[~bit_cnt];
          end
        end
        RD_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
          end else if (scl_rise) begin
            ptr_n = ptr + 8'd1;
            if (sda_f) begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end else begin
              state_n   = RD_DATA;
              bit_cnt_n = 3'd0;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 8'd0;
      ptr     <= 8'd0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      ack_drv <= 1'b0;
      rw      <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= 8'd0;
      wr_data <= 8'd0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      ptr     <= ptr_n;
      sda_oe  <= sda_oe_n;
      busy    <= busy_n;
      ack_drv <= ack_drv_n;
      rw      <= rw_n;
      wr_stb  <= wr_stb_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
    end
  end

  // Register file keeps its contents across reset.
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_rst) mem[ptr] <= rx_byte;
  end

  assign bus.sda_oe    = sda_oe;
  assign bus.busy      = busy;
  assign bus.wr_stb    = wr_stb;
  assign bus.wr_addr   = wr_addr;
  assign bus.wr_data   = wr_data;
  assign bus.dbg_state = state;
endmodule

// File: doc/i2c_slave_regs.md
I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 Parameter SLV_ADDR, default 7'h50: the 7-bit device address this slave answers to.
REQ-002 Parameter FILT_LEN, default 3: number of consecutive equal samples needed to accept a change on scl or sda.
REQ-003 i_clk  input  1: single system clock, at least 8x the scl frequency.
REQ-004 i_rst  input  1: synchronous, active-high reset.
REQ-005 scl_i  input  1: bus clock as seen on the pin.
REQ-006 sda_i  input  1: bus data as seen on the pin.
REQ-007 sda_oe  output  1: 1 pulls the sda pin low; 0 releases it (open-drain, pull-up external).
REQ-008 wr_stb  output  1: one-cycle pulse when a received data byte is committed to memory.
REQ-009 wr_addr  output  8: address of the committed byte, valid while wr_stb is 1.
REQ-010 wr_data  output  8: value of the committed byte, valid while wr_stb is 1.
REQ-011 busy  output  1: 1 from an addressed START until the following STOP or START.

Function
REQ-012 scl_i and sda_i SHALL pass through a 2-flop synchronizer, then a FILT_LEN glitch filter, before any use.
REQ-013 Edge detection runs on the filtered signals: rise, fall, START (sda falls while scl is high) and STOP (sda rises while scl is high).
REQ-014 The FSM SHALL have these states: IDLE, DEV_ADDR, DEV_ACK, WORD_ADDR, WORD_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-015 A START from any state SHALL go to DEV_ADDR, clear the bit counter and release sda_oe; this covers repeated START.
REQ-016 A STOP from any state SHALL go to IDLE with sda_oe=0 and busy=0.
REQ-017 Bits SHALL be sampled on the filtered scl rise, MSB first, 8 bits per byte.
REQ-018 sda_oe SHALL change only on the filtered scl fall, never while scl is high.
REQ-019 After the 8th bit of DEV_ADDR:
- if bits[7:1]==SLV_ADDR, go to DEV_ACK and drive sda_oe=1 for one scl period;
- otherwise go to IDLE with no ACK.
REQ-020 bit0 of the address byte: 0 gives DEV_ACK->WORD_ADDR; 1 gives DEV_ACK->RD_DATA.
REQ-021 WORD_ADDR: the received byte loads the 8-bit pointer, then WORD_ACK (ACK driven), then WR_DATA.
REQ-022 WR_DATA: on the 8th bit, mem[pointer]<=byte and wr_stb pulses for one i_clk with wr_addr=pointer and wr_data=byte. Then go to WR_ACK (ACK driven), pointer+1, then back to WR_DATA.
REQ-023 RD_DATA: the slave drives sda_oe = ~bit of mem[pointer], MSB first. Each bit is updated on scl fall; the first bit is set on the fall that ends DEV_ACK or RD_ACK.
REQ-024 RD_ACK: the slave releases sda and samples the master bit on scl rise, and the pointer increments.
- master ACK (0): go to RD_DATA with the next byte;
- master NACK (1): go to IDLE and keep sda released.
REQ-025 The pointer is 8 bits and wraps 8'hFF->8'h00 on both read and write.
REQ-026 The memory is 256x8 and is read combinationally from the pointer.
REQ-027 A STOP or START mid-byte SHALL abort that byte: no memory write and no wr_stb.
REQ-028 busy rises on a matching address (entry to DEV_ACK) and falls on STOP, START or IDLE entry.
REQ-029 While IDLE the block ignores all scl edges; only START is recognised.

Reset
REQ-030 While i_rst=1 at a clock edge:
- state=IDLE;
- sda_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0;
- pointer=0 and bit counter=0;
- synchronizer and filter flops preset to 1.
REQ-031 Memory contents SHALL NOT be affected by reset.
REQ-032 Reset asserted mid-transfer SHALL release sda within 1 i_clk, and the next START SHALL be handled normally.

Verification
REQ-033 Write: START, A0, 10, 5A, C3, STOP -> ACK on all 4 bytes; wr_stb at addr 10=5A and addr 11=C3; busy falls after STOP.
REQ-034 Random read: START, A0, 10, repeated START, A1, master ACK, master NACK, STOP -> slave returns 5A then C3; sda released after the NACK.
REQ-035 Wrong address: START, A2, ... -> no ACK (sda_oe stays 0), busy stays 0, no wr_stb.
REQ-036 Wrap: write pointer FF with bytes 11, 22 -> wr_stb FF=11 then 00=22.
REQ-037 Abort: STOP after 4 bits of a data byte -> no wr_stb, state IDLE; a 1-i_clk sda glitch while scl is high -> no START or STOP detected.
REQ-038 Reset during RD_DATA with sda_oe=1 -> sda_oe=0 on the next cycle; a following write transaction completes correctly.
